hci_ecc_err_collector: RTL
==========================

// Module: hci_ecc_err_collector
// PURPOSE
// - Sits directly downstream of the HCI ECC decoder. Consumes its per-transfer error outputs:
//   data single/multi popcounts and meta single/multi flags.
// - Accumulates them into saturating counters and raises sticky status and an interrupt.
// - Exposes everything through a small word-addressed HCI-style register port (req/gnt, 1-cycle r_valid).
// PARAMETERS
// - N_CHUNK   4   DW/CHUNK_SIZE of the feeding decoder
// - MAX_ERR   $clog2(N_CHUNK)+1   width of the popcount inputs (derived, do not override)
// - CNTW      16  counter width, 1..32
// - AW        32  address width of the logged transfer address
// PORTS
// - clk_i               in   1        clock
// - clear_i             in   1        reset, synchronous, active-high
// - evt_valid_i         in   1        error inputs qualified this cycle (decoder req & gnt)
// - data_single_err_i   in   MAX_ERR  corrected data chunks this transfer
// - data_multi_err_i    in   MAX_ERR  uncorrectable data chunks this transfer
// - meta_single_err_i   in   1        corrected metadata error
// - meta_multi_err_i    in   1        uncorrectable metadata error
// - evt_add_i           in   AW       transfer address (used only with the macro)
// - cfg_req_i           in   1        register access request
// - cfg_gnt_o           out  1        grant; tied to 1
// - cfg_add_i           in   3        register word index
// - cfg_wen_i           in   1        1 = read, 0 = write (HCI polarity)
// - cfg_data_i          in   32       write data
// - cfg_r_valid_o       out  1        read/write response, 1 cycle after req
// - cfg_r_data_o        out  32       read data; 0 for writes
// - irq_o               out  1        level interrupt
// BEHAVIOUR
// - Reset: all counters, STATUS, THRESHOLD and ERR_ADDR are 0. cfg_r_valid_o=0, cfg_r_data_o=0, irq_o=0.
// - Register map (index):
//   - 0 DCORR, 1 DUNCORR, 2 MCORR, 3 MUNCORR: zero-extended counters. Any write clears the counter.
//   - 4 THRESH: RW, low CNTW bits. 0 disables the threshold.
//   - 5 STATUS: bit0 THR, bit1 UNCORR, bit2 SAT; write-1-to-clear.
//   - 6 ERR_ADDR; 7 reads 0, writes ignored.
// - Counting, only when evt_valid_i=1:
//   - DCORR += data_single_err_i, DUNCORR += data_multi_err_i.
//   - MCORR += meta_single_err_i, MUNCORR += meta_multi_err_i.
//   - Sums are computed at CNTW+1 bits. A result above 2^CNTW-1 saturates to all-ones and sets STATUS.SAT.
//   - A saturated counter holds until cleared.
// - Status:
//   - THR sets when THRESH!=0 and the DCORR next value >= THRESH.
//   - UNCORR sets on any nonzero data_multi_err_i or meta_multi_err_i with evt_valid_i.
//   - Bits stay set until W1C.
// - irq_o = |STATUS, registered. It asserts the cycle after the causing event.
// - Simultaneous write and event on the same counter:
//   - The clear applies first, then the event is added, so no event is lost.
//   - Counter = event amount next cycle.
// - Simultaneous W1C and set on the same STATUS bit: set wins.
// - Register port:
//   - Accepted every cycle (gnt=1).
//   - Response registered: r_valid and r_data one cycle after req.
//   - Reads return the pre-update value of that cycle.
// - clear_i mid-access: the pending response is dropped (r_valid=0 next cycle) and all state returns to reset values.
// CONFIGURATION
// - Macro HCI_ECC_ERR_ADDR_LOG_EN.
// - Defined:
//   - On the first uncorrectable event while STATUS.UNCORR=0, ERR_ADDR captures evt_add_i.
//   - ERR_ADDR is frozen until UNCORR is cleared via W1C.
//   - If the W1C and a new event coincide, the new address is captured.
// - Undefined: no ERR_ADDR flop, index 6 reads 0, evt_add_i unused.
// STRUCTURE
// - hci_package additions:
//   - typedef enum logic [2:0] hci_ecc_err_reg_e (HCI_ECC_REG_DCORR..HCI_ECC_REG_ERRADDR).
//   - Localparams for the STATUS bit indices.
//   - DEFAULT_ECC_CNTW=16.
// - Sub-module hci_ecc_sat_counter (WIDTH, INCW):
//   - Ports: clk_i, clear_i, clr_i, inc_valid_i, inc_i, cnt_o, sat_o.
//   - Instantiated 4x.
// TESTING
// - Reset, then read all 8 indices -> all responses 0, r_valid exactly 1 cycle after each req, irq_o=0.
// - 5 events with data_single_err_i=3, THRESH=12:
//   - DCORR=15.
//   - THR set on the 4th event (12); irq_o high the next cycle.
//   - W1C STATUS=1 -> irq_o=0.
// - CNTW=4, 6 events with data_single_err_i=3 -> DCORR=15 (not 18 mod 16), STATUS.SAT=1.
// - Write DCORR in the same cycle as an event with data_single_err_i=2, DCORR=9 before -> DCORR=2.
// - meta_multi_err_i=1 with evt_add_i=0x1000_0040, then a second event with evt_add_i=0x1000_0080:
//   - MUNCORR=2, STATUS.UNCORR=1.
//   - With the macro, ERR_ADDR=0x1000_0040; without it, ERR_ADDR reads 0.
// - Assert clear_i while a read is in flight -> r_valid=0 next cycle, all counters 0.

Source files
------------

// File: rtl/hci_ecc_err_collector_pkg.sv
// Shared definitions for the HCI ECC error collector.
// Contents:
//   hci_ecc_err_reg_e  - register word indices of the configuration port
//   STATUS_*_BIT       - bit positions inside the STATUS register
//   DEFAULT_ECC_CNTW   - default counter width
package hci_ecc_err_collector_pkg;

  typedef enum logic [2:0] {
    HCI_ECC_REG_DCORR   = 3'd0,
    HCI_ECC_REG_DUNCORR = 3'd1,
    HCI_ECC_REG_MCORR   = 3'd2,
    HCI_ECC_REG_MUNCORR = 3'd3,
    HCI_ECC_REG_THRESH  = 3'd4,
    HCI_ECC_REG_STATUS  = 3'd5,
    HCI_ECC_REG_ERRADDR = 3'd6,
    HCI_ECC_REG_RSVD    = 3'd7
  } hci_ecc_err_reg_e;

  localparam int unsigned STATUS_THR_BIT    = 0;
  localparam int unsigned STATUS_UNCORR_BIT = 1;
  localparam int unsigned STATUS_SAT_BIT    = 2;
  localparam int unsigned STATUS_W          = 3;

  localparam int unsigned DEFAULT_ECC_CNTW = 16;

endpackage

// File: rtl/hci_ecc_sat_counter.sv
// Saturating event counter.
// A register-port clear (clr_i) is applied before the increment of the same cycle, so an
// event coinciding with a clear is never lost. A sum above 2^WIDTH-1 saturates to all-ones.
// Ports:
//   clk_i        clock
//   clear_i      synchronous active-high reset
//   clr_i        software clear of the count
//   inc_valid_i  increment qualifier
//   inc_i        increment amount
//   cnt_o        current count
//   sat_o        pulses in the cycle an increment overflows
module hci_ecc_sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned INCW  = 3
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             clr_i,
  input  logic             inc_valid_i,
  input  logic [INCW-1:0]  inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             sat_o
);

  // Sum width covers both operands plus a carry bit.
  localparam int unsigned SW = ((INCW > WIDTH) ? INCW : WIDTH) + 1;
  localparam logic [SW-1:0] MaxCnt = (SW'(1) << WIDTH) - SW'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_d;
  logic [SW-1:0]    w_base;
  logic [SW-1:0]    w_sum;
  logic             w_ovf;

  always_comb begin
    w_base  = clr_i ? '0 : SW'(r_cnt);
    w_sum   = w_base + SW'(inc_i);
    w_ovf   = inc_valid_i && (w_sum > MaxCnt);
    w_cnt_d = w_base[WIDTH-1:0];
    if (inc_valid_i) begin
      w_cnt_d = w_ovf ? '1 : w_sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign cnt_o = r_cnt;
  assign sat_o = w_ovf;

endmodule

// File: rtl/hci_ecc_err_collector.sv
// HCI ECC error collector.
// Accumulates per-transfer error reports from the HCI ECC decoder into four saturating
// counters, keeps sticky STATUS bits, drives a level interrupt and exposes everything through
// a word-addressed req/gnt register port with a registered one-cycle response.
// Optional feature: define HCI_ECC_ERR_ADDR_LOG_EN to log the address of the first
// uncorrectable transfer in ERR_ADDR (index 6); otherwise index 6 reads 0.
// Ports:
//   clk_i / clear_i        clock, synchronous active-high reset
//   evt_valid_i            error inputs qualified this cycle
//   data_single_err_i      corrected data chunks this transfer
//   data_multi_err_i       uncorrectable data chunks this transfer
//   meta_single_err_i      corrected metadata error
//   meta_multi_err_i       uncorrectable metadata error
//   evt_add_i              transfer address
//   cfg_req_i / cfg_gnt_o  register request / grant (always granted)
//   cfg_add_i              register word index
//   cfg_wen_i              1 = read, 0 = write
//   cfg_data_i             write data
//   cfg_r_valid_o          response valid, one cycle after request
//   cfg_r_data_o           read data (0 for writes)
//   irq_o                  level interrupt, OR of STATUS
module hci_ecc_err_collector
  import hci_ecc_err_collector_pkg::*;
#(
  parameter int unsigned N_CHUNK = 4,
  parameter int unsigned CNTW    = DEFAULT_ECC_CNTW,
  parameter int unsigned AW      = 32,
  localparam int unsigned MAX_ERR = $clog2(N_CHUNK) + 1
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic               evt_valid_i,
  input  logic [MAX_ERR-1:0] data_single_err_i,
  input  logic [MAX_ERR-1:0] data_multi_err_i,
  input  logic               meta_single_err_i,
  input  logic               meta_multi_err_i,
  input  logic [AW-1:0]      evt_add_i,
  input  logic               cfg_req_i,
  output logic               cfg_gnt_o,
  input  logic [2:0]         cfg_add_i,
  input  logic               cfg_wen_i,
  input  logic [31:0]        cfg_data_i,
  output logic               cfg_r_valid_o,
  output logic [31:0]        cfg_r_data_o,
  output logic               irq_o
);

  localparam int unsigned TW = ((MAX_ERR > CNTW) ? MAX_ERR : CNTW) + 1;

  hci_ecc_err_reg_e w_reg;
  logic             w_wr;
  logic             w_rd;
  logic [3:0]       w_cnt_clr;
  logic [3:0]       w_cnt_sat;
  logic [CNTW-1:0]  w_dcorr;
  logic [CNTW-1:0]  w_duncorr;
  logic [CNTW-1:0]  w_mcorr;
  logic [CNTW-1:0]  w_muncorr;
  logic [TW-1:0]    w_thr_sum;
  logic             w_thr_hit;
  logic             w_wr_status;
  logic [STATUS_W-1:0] w_status_set;
  logic [STATUS_W-1:0] w_status_d;
  logic [31:0]      w_rd_data;
  logic [31:0]      w_err_addr_rd;
  logic             w_unused;

  logic [CNTW-1:0]     r_thresh;
  logic [STATUS_W-1:0] r_status;
  logic                r_irq;
  logic                r_valid;
  logic [31:0]         r_data;

  assign cfg_gnt_o   = 1'b1;
  assign w_reg       = hci_ecc_err_reg_e'(cfg_add_i);
  assign w_wr        = cfg_req_i && !cfg_wen_i;
  assign w_rd        = cfg_req_i && cfg_wen_i;
  assign w_wr_status = w_wr && (w_reg == HCI_ECC_REG_STATUS);

  // Any write to a counter index clears that counter.
  always_comb begin
    w_cnt_clr = '0;
    if (w_wr && !cfg_add_i[2]) begin
      w_cnt_clr[cfg_add_i[1:0]] = 1'b1;
    end
  end

  hci_ecc_sat_counter #(
    .WIDTH (CNTW),
    .INCW  (MAX_ERR)
  ) u_cnt_dcorr (
    .clk_i       (clk_i),
    .clear_i     (clear_i),
    .clr_i       (w_cnt_clr[0]),
    .inc_valid_i (evt_valid_i),
    .inc_i       (data_single_err_i),
    .cnt_o       (w_dcorr),
    .sat_o       (w_cnt_sat[0])
  );

  hci_ecc_sat_counter #(
    .WIDTH (CNTW),
    .INCW  (MAX_ERR)
  ) u_cnt_duncorr (
    .clk_i       (clk_i),
    .clear_i     (clear_i),
    .clr_i       (w_cnt_clr[1]),
    .inc_valid_i (evt_valid_i),
    .inc_i       (data_multi_err_i),
    .cnt_o       (w_duncorr),
    .sat_o       (w_cnt_sat[1])
  );

  hci_ecc_sat_counter #(
    .WIDTH (CNTW),
    .INCW  (1)
  ) u_cnt_mcorr (
    .clk_i       (clk_i),
    .clear_i     (clear_i),
    .clr_i       (w_cnt_clr[2]),
    .inc_valid_i (evt_valid_i),
    .inc_i       (meta_single_err_i),
    .cnt_o       (w_mcorr),
    .sat_o       (w_cnt_sat[2])
  );

  hci_ecc_sat_counter #(
    .WIDTH (CNTW),
    .INCW  (1)
  ) u_cnt_muncorr (
    .clk_i       (clk_i),
    .clear_i     (clear_i),
    .clr_i       (w_cnt_clr[3]),
    .inc_valid_i (evt_valid_i),
    .inc_i       (meta_multi_err_i),
    .cnt_o       (w_muncorr),
    .sat_o       (w_cnt_sat[3])
  );

  // Since THRESH never exceeds the saturation value, comparing the unsaturated sum is
  // equivalent to comparing DCORR's saturated next value.
  always_comb begin
    w_thr_sum = (w_cnt_clr[0] ? '0 : TW'(w_dcorr)) + TW'(data_single_err_i);
    w_thr_hit = evt_valid_i && (|r_thresh) && (w_thr_sum >= TW'(r_thresh));
  end

  // Set has priority over write-1-to-clear.
  always_comb begin
    w_status_set                    = '0;
    w_status_set[STATUS_THR_BIT]    = w_thr_hit;
    w_status_set[STATUS_UNCORR_BIT] = evt_valid_i && ((|data_multi_err_i) || meta_multi_err_i);
    w_status_set[STATUS_SAT_BIT]    = |w_cnt_sat;
    w_status_d = r_status;
    if (w_wr_status) begin
      w_status_d = r_status & ~cfg_data_i[STATUS_W-1:0];
    end
    w_status_d = w_status_d | w_status_set;
  end

`ifdef HCI_ECC_ERR_ADDR_LOG_EN
  logic [AW-1:0] r_err_addr;
  logic          w_addr_cap;

  // Capture only while UNCORR is clear, or when software clears it in the same cycle.
  assign w_addr_cap = w_status_set[STATUS_UNCORR_BIT] &&
                      (!r_status[STATUS_UNCORR_BIT] ||
                       (w_wr_status && cfg_data_i[STATUS_UNCORR_BIT]));

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_err_addr <= '0;
    end else if (w_addr_cap) begin
      r_err_addr <= evt_add_i;
    end
  end

  assign w_err_addr_rd = 32'(r_err_addr);
  assign w_unused      = ^cfg_data_i;
`else
  assign w_err_addr_rd = '0;
  assign w_unused      = ^{cfg_data_i, evt_add_i};
`endif

  always_comb begin
    w_rd_data = '0;
    unique case (w_reg)
      HCI_ECC_REG_DCORR:   w_rd_data = 32'(w_dcorr);
      HCI_ECC_REG_DUNCORR: w_rd_data = 32'(w_duncorr);
      HCI_ECC_REG_MCORR:   w_rd_data = 32'(w_mcorr);
      HCI_ECC_REG_MUNCORR: w_rd_data = 32'(w_muncorr);
      HCI_ECC_REG_THRESH:  w_rd_data = 32'(r_thresh);
      HCI_ECC_REG_STATUS:  w_rd_data = 32'(r_status);
      HCI_ECC_REG_ERRADDR: w_rd_data = w_err_addr_rd;
      HCI_ECC_REG_RSVD:    w_rd_data = '0;
      default:             w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      r_thresh <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      if (w_wr && (w_reg == HCI_ECC_REG_THRESH)) begin
        r_thresh <= cfg_data_i[CNTW-1:0];
      end
      r_status <= w_status_d;
      r_irq    <= |w_status_d;
      r_valid  <= cfg_req_i;
      r_data   <= w_rd ? w_rd_data : '0;
    end
  end

  assign cfg_r_valid_o = r_valid;
  assign cfg_r_data_o  = r_data;
  assign irq_o         = r_irq;

endmodule
